// File: rtl/trigger_framer_pkg.sv
// trigger_framer_pkg
//   Shared definitions for the trigger framer slice: the control state
//   encoding and the edge-slope selector constants.
package trigger_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_framer_if.sv
// trigger_framer_if
//   Valid/ready sample stream carrying captured frames towards the
//   display/host path.
//   data  : frame sample
//   valid : data is valid this cycle
//   ready : sink accepts this cycle
//   last  : final sample of the frame
//   master modport = framer side, slave modport = sink side.
interface trigger_framer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );

endinterface

// File: rtl/trigger_framer_edge_detect.sv
// trigger_framer_edge_detect
//   Combinational level-crossing test between the previous sample and the
//   current FIFO head. All compares are unsigned.
//   prev_valid : previous sample is meaningful and the head is present
//   prev       : previous sample p
//   head       : current head sample h
//   level      : trigger level
//   slope      : SLOPE_RISING or SLOPE_FALLING
//   hit        : crossing detected
module trigger_framer_edge_detect
  import trigger_framer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] head,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              hit
);

  always_comb begin
    hit = 1'b0;
    if (prev_valid) begin
      if (slope == SLOPE_RISING) begin
        hit = (prev < level) && (head >= level);
      end else begin
        hit = (prev > level) && (head <= level);
      end
    end
  end

endmodule

// File: rtl/trigger_framer.sv
// trigger_framer
//   Drains ADC samples from a show-ahead FIFO, searches for an edge
//   crossing of a programmable level and forwards a frame of samples,
//   starting at the trigger sample, on a valid/ready stream.
//   clk_i        : FIFO read-side clock
//   rst_i        : synchronous active-high reset
//   fifo_empty_i : FIFO empty flag
//   fifo_data_i  : head-of-FIFO sample
//   fifo_inc_o   : pop request
//   arm_i        : start a trigger search (IDLE only)
//   force_i      : immediate trigger (ARMED only)
//   abort_i      : return to IDLE, highest priority
//   slope_i      : 0 rising, 1 falling
//   level_i      : trigger level
//   frame_len_i  : samples per frame, 0 treated as 1
//   out_if       : frame output stream (master)
//   busy_o       : ARMED or CAPTURE
//   triggered_o  : one-cycle pulse after entering CAPTURE
module trigger_framer
  import trigger_framer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_inc_o,
  input  logic              arm_i,
  input  logic              force_i,
  input  logic              abort_i,
  input  logic              slope_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  trigger_framer_if.master  out_if,
  output logic              busy_o,
  output logic              triggered_o
);

  state_e            state_q;
  logic              slope_q;
  logic [DATA_W-1:0] level_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;
  logic              busy_q;
  logic              trig_q;

  logic hit;
  logic take_trigger;
  logic handshake;
  logic is_last;

  // The head only takes part in a crossing once a previous sample exists.
  trigger_framer_edge_detect #(
    .DATA_W(DATA_W)
  ) u_edge_detect (
    .prev_valid(prev_valid_q & ~fifo_empty_i),
    .prev      (prev_q),
    .head      (fifo_data_i),
    .level     (level_q),
    .slope     (slope_q),
    .hit       (hit)
  );

  assign take_trigger = (state_q == ST_ARMED) && (force_i || hit);
  assign handshake    = out_if.valid && out_if.ready;
  assign is_last      = (count_q == len_q - LEN_W'(1));

  // Stream and pop controls are combinational so capture passes samples
  // through with no added latency. Reset and abort suppress all of them so
  // no sample is consumed or presented while the block is being torn down.
  always_comb begin
    fifo_inc_o   = 1'b0;
    out_if.valid = 1'b0;
    out_if.last  = 1'b0;
    out_if.data  = '0;
    if (!rst_i && !abort_i) begin
      case (state_q)
        ST_ARMED: begin
          // Hold the trigger sample at the head so it opens the frame.
          fifo_inc_o = !fifo_empty_i && !take_trigger;
        end
        ST_CAPTURE: begin
          out_if.valid = !fifo_empty_i;
          out_if.last  = !fifo_empty_i && is_last;
          out_if.data  = fifo_data_i;
          fifo_inc_o   = !fifo_empty_i && out_if.ready;
        end
        default: begin
          fifo_inc_o = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      slope_q      <= SLOPE_RISING;
      level_q      <= '0;
      len_q        <= LEN_W'(1);
      count_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm_i) begin
              state_q      <= ST_ARMED;
              busy_q       <= 1'b1;
              slope_q      <= slope_i;
              level_q      <= level_i;
              len_q        <= (frame_len_i == '0) ? LEN_W'(1) : frame_len_i;
              prev_valid_q <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (take_trigger) begin
              state_q <= ST_CAPTURE;
              count_q <= '0;
              trig_q  <= 1'b1;
            end else if (!fifo_empty_i) begin
              prev_q       <= fifo_data_i;
              prev_valid_q <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            if (handshake) begin
              count_q <= count_q + LEN_W'(1);
              if (is_last) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign triggered_o = trig_q;

endmodule
